// File: rtl/alu_control_decoder.sv
// ALU control decoder: ALUOp + funct fields -> 3-bit ALU control code, with valid and illegal flags.
// Latency: 1 cycle, registered. Backpressure: none, so a new decode is accepted every cycle.
// Optional: ALU_DECODER_EXT_OPS_EN adds the xor/sll/srl codes.
module alu_control_decoder (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic [1:0] ALUOP1_0,
    input  logic       OP_5,
    input  logic [2:0] funct3_2_0,
    input  logic       funct7_5,
    output logic [2:0] ALUControl2_0,
    output logic       OUT_VALID,
    output logic       ILLEGAL
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
`ifdef ALU_DECODER_EXT_OPS_EN
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;
`endif

    logic [2:0] w_code;
    logic       w_illegal;

    logic [2:0] r_code;
    logic       r_valid;
    logic       r_illegal;

    always_comb begin
        w_code    = ALU_ADD;
        w_illegal = 1'b0;
        case (ALUOP1_0)
            2'b00: w_code = ALU_ADD;
            2'b01: w_code = ALU_SUB;
            2'b10: begin
                case (funct3_2_0)
                    // Only R-type with funct7[5] set is sub; addi never is.
                    3'b000: w_code = (OP_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010: w_code = ALU_SLT;
                    3'b110: w_code = ALU_OR;
                    3'b111: w_code = ALU_AND;
`ifdef ALU_DECODER_EXT_OPS_EN
                    3'b100: w_code = ALU_XOR;
                    3'b001: w_code = ALU_SLL;
                    3'b101: begin
                        if (funct7_5) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_code = ALU_SRL;
                        end
                    end
`endif
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_code    <= ALU_ADD;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= IN_VALID;
            if (IN_VALID) begin
                r_code    <= w_code;
                r_illegal <= w_illegal;
            end
        end
    end

    assign ALUControl2_0 = r_code;
    assign OUT_VALID     = r_valid;
    assign ILLEGAL       = r_illegal;

endmodule

// File: tb/tb_alu_control_decoder.sv
// Bench for alu_control_decoder: directed walk through the decode table, then randomized traffic
// compared against a table-driven reference model.
module tb_alu_control_decoder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic [1:0] ALUOP1_0;
    logic       OP_5;
    logic [2:0] funct3_2_0;
    logic       funct7_5;
    logic [2:0] ALUControl2_0;
    logic       OUT_VALID;
    logic       ILLEGAL;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_code;
    logic       exp_vld;
    logic       exp_ill;

    // Reference tables for ALUOp=10, indexed by funct3.
    logic [2:0] r_tbl_code [8];
    logic       r_tbl_ok   [8];

    alu_control_decoder dut (
        .CLK           (CLK),
        .RST           (RST),
        .IN_VALID      (IN_VALID),
        .ALUOP1_0      (ALUOP1_0),
        .OP_5          (OP_5),
        .funct3_2_0    (funct3_2_0),
        .funct7_5      (funct7_5),
        .ALUControl2_0 (ALUControl2_0),
        .OUT_VALID     (OUT_VALID),
        .ILLEGAL       (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [1:0] aluop, input logic op5,
                                              input logic [2:0] f3, input logic f7);
        // Returns {illegal, code}.
        if (aluop == 2'd0) return {1'b0, 3'd0};
        if (aluop == 2'd1) return {1'b0, 3'd1};
        if (aluop == 2'd3) return {1'b1, 3'd0};
        if (f3 == 3'd0)    return {1'b0, (op5 & f7) ? 3'd1 : 3'd0};
`ifdef ALU_DECODER_EXT_OPS_EN
        if (f3 == 3'd5 && f7) return {1'b1, 3'd0};
`endif
        if (r_tbl_ok[f3]) return {1'b0, r_tbl_code[f3]};
        return {1'b1, 3'd0};
    endfunction

    task automatic step(input string tag);
        logic [3:0] r;
        @(posedge CLK);
        if (RST) begin
            exp_code = 3'd0; exp_vld = 1'b0; exp_ill = 1'b0;
        end else begin
            exp_vld = IN_VALID;
            if (IN_VALID) begin
                r = ref_decode(ALUOP1_0, OP_5, funct3_2_0, funct7_5);
                exp_code = r[2:0];
                exp_ill  = r[3];
            end
        end
        #1;
        chk({tag, ".code"},  32'(ALUControl2_0), 32'(exp_code));
        chk({tag, ".valid"}, 32'(OUT_VALID),     32'(exp_vld));
        chk({tag, ".ill"},   32'(ILLEGAL),       32'(exp_ill));
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [1:0] aop,
                         input logic op5, input logic [2:0] f3, input logic f7);
        RST = rst; IN_VALID = vld; ALUOP1_0 = aop; OP_5 = op5; funct3_2_0 = f3; funct7_5 = f7;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            r_tbl_code[i] = 3'd0;
            r_tbl_ok[i]   = 1'b0;
        end
        r_tbl_code[2] = 3'b101; r_tbl_ok[2] = 1'b1;
        r_tbl_code[6] = 3'b011; r_tbl_ok[6] = 1'b1;
        r_tbl_code[7] = 3'b010; r_tbl_ok[7] = 1'b1;
`ifdef ALU_DECODER_EXT_OPS_EN
        r_tbl_code[4] = 3'b100; r_tbl_ok[4] = 1'b1;
        r_tbl_code[1] = 3'b110; r_tbl_ok[1] = 1'b1;
        r_tbl_code[5] = 3'b111; r_tbl_ok[5] = 1'b1;
`endif
        exp_code = 3'd0; exp_vld = 1'b0; exp_ill = 1'b0;

        drive(1, 1, 2'b11, 0, 3'b101, 1);
        step("rst0");
        step("rst1");
        drive(0, 0, 2'b00, 0, 3'b000, 0);
        step("idle");

        drive(0, 1, 2'b00, 0, 3'b110, 0); step("ldst");
        drive(0, 1, 2'b01, 1, 3'b111, 1); step("branch");
        drive(0, 1, 2'b10, 0, 3'b000, 1); step("addi_f7");
        drive(0, 1, 2'b10, 1, 3'b000, 1); step("sub");
        drive(0, 1, 2'b10, 1, 3'b000, 0); step("add");
        drive(0, 1, 2'b10, 1, 3'b010, 0); step("slt");
        drive(0, 1, 2'b10, 1, 3'b110, 0); step("or");
        drive(0, 1, 2'b10, 1, 3'b111, 0); step("and");
        drive(0, 1, 2'b11, 0, 3'b101, 1); step("aluop11");
        drive(0, 0, 2'b00, 0, 3'b000, 0); step("hold");
        drive(0, 1, 2'b10, 1, 3'b101, 0); step("srl");
        drive(0, 1, 2'b10, 1, 3'b101, 1); step("sra");
        drive(0, 1, 2'b10, 1, 3'b011, 0); step("sltu");
        drive(0, 1, 2'b10, 1, 3'b010, 0); step("pre_rst");
        drive(1, 1, 2'b10, 1, 3'b110, 0); step("rst_mid");

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
